// File: rtl/alu8_issue_if.sv
// Command, ALU-side and result signals of the alu8_issue command front end.
// The slave modport is the front end itself; the master side is the requester plus the ALU.
interface alu8_issue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_mode;
    logic [7:0]    cmd_left;
    logic [7:0]    cmd_right;
    logic          cmd_acc;

    logic [7:0]    alu_left;
    logic [7:0]    alu_right;
    logic [1:0]    alu_mode;
    logic [7:0]    alu_result;

    logic          res_valid;
    logic [7:0]    res_data;
    logic          res_ready;

    logic [CW-1:0] count;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_left, cmd_right, cmd_acc,
        input  alu_result, res_ready,
        output cmd_ready, alu_left, alu_right, alu_mode,
        output res_valid, res_data, count
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_left, cmd_right, cmd_acc,
        output alu_result, res_ready,
        input  cmd_ready, alu_left, alu_right, alu_mode,
        input  res_valid, res_data, count
    );
endinterface

// File: rtl/alu8_issue.sv
// Command FIFO in front of an 8-bit combinational ALU: issues one command at a time,
// captures the result into an accumulator and hands it out over valid/ready.
module alu8_issue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu8_issue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] left;
        logic [7:0] right;
        logic       acc;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    state_t        r_state, w_state_nxt;
    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [7:0]    r_acc;

    logic          w_full, w_push, w_pop;
    cmd_t          w_head, w_push_cmd;
    logic [7:0]    w_alu_left, w_alu_right;
    logic [1:0]    w_alu_mode;

    // Ready is purely a function of occupancy: a pop in the same cycle does not free a slot.
    assign w_full        = (r_count == CW'(DEPTH));
    assign w_push        = bus.cmd_valid && !w_full;
    assign w_pop         = (r_state == S_ISSUE);
    assign w_head        = r_mem[r_rptr];
    assign w_push_cmd    = {bus.cmd_mode, bus.cmd_left, bus.cmd_right, bus.cmd_acc};

    assign bus.cmd_ready = !w_full;
    assign bus.count     = r_count;
    assign bus.res_valid = (r_state == S_HOLD);
    assign bus.res_data  = r_acc;
    assign bus.alu_left  = w_alu_left;
    assign bus.alu_right = w_alu_right;
    assign bus.alu_mode  = w_alu_mode;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_push_cmd;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                r_acc  <= bus.alu_result;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_alu_left  = '0;
        w_alu_right = '0;
        w_alu_mode  = '0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0)
                    w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_alu_mode  = w_head.mode;
                w_alu_right = w_head.right;
                w_alu_left  = w_head.acc ? r_acc : w_head.left;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // A push landing on the same edge as the result handoff still counts.
                if (bus.res_ready)
                    w_state_nxt = (w_count_nxt != '0) ? S_ISSUE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    a_pop_nonempty: assert property (@(posedge clk) disable iff (rst) w_pop |-> (r_count != '0));
    a_count_bound:  assert property (@(posedge clk) disable iff (rst) r_count <= CW'(DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) w_full |-> !w_push);
endmodule

// File: tb/tb_alu8_issue.sv
// Bench for alu8_issue: behavioural ALU, result scoreboard fed by accepted commands,
// a vector table, directed multi-cycle sequences and a randomized phase.
module tb_alu8_issue;
    localparam int DEPTH = 4;

    logic clk, rst;
    int   n_checks, n_fail, cyc, n_res;

    alu8_issue_if #(.DEPTH(DEPTH)) bus ();
    alu8_issue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    // The team ALU.
    assign bus.alu_result = (bus.alu_mode == 2'd0) ? bus.alu_left + bus.alu_right :
                            (bus.alu_mode == 2'd1) ? bus.alu_left - bus.alu_right :
                            (bus.alu_mode == 2'd2) ? (bus.alu_left & bus.alu_right) :
                                                     (bus.alu_left | bus.alu_right);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] ref_op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        case (m)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each accepted command's result follows from the previous result in order.
    logic [7:0] exp_q[$];
    logic [7:0] m_acc;
    logic [7:0] m_left;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_acc = 8'h00;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                m_left = bus.cmd_acc ? m_acc : bus.cmd_left;
                m_acc  = ref_op(bus.cmd_mode, m_left, bus.cmd_right);
                exp_q.push_back(m_acc);
            end
            if (bus.res_valid && bus.res_ready) begin
                n_res++;
                if (exp_q.size() == 0)
                    check("unexpected result", 32'(bus.res_data), 32'hFFFF_FFFF);
                else
                    check("result order", 32'(bus.res_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] l,
                         input logic [7:0] r, input logic a);
        bus.cmd_valid = v;
        bus.cmd_mode  = m;
        bus.cmd_left  = l;
        bus.cmd_right = r;
        bus.cmd_acc   = a;
    endtask

    task automatic rand_cmd();
        drive(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic full_cmd(input int i);
        if (i < 6) drive(1'b1, 2'(i), 8'(16 * i + 3), 8'(33 + i), 1'b0);
        else       bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (exp_q.size() == 0 && bus.count == '0 && !bus.res_valid) break;
            step();
        end
        check({nm, " scoreboard empty"}, 32'(exp_q.size()), 32'd0);
        check({nm, " count"}, 32'(bus.count), 32'd0);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] left;
        logic [7:0] right;
        logic       acc;
        logic [7:0] exp_left;
        logic [7:0] exp_res;
    } vec_t;

    vec_t tbl [10];
    int   lat, idx, n0;
    logic acc_now;
    int   t_res [3];
    logic [7:0] d_res [3];
    int   n_seen, c_acc;

    initial begin
        tbl[0] = '{2'd0, 8'hF0, 8'h20, 1'b0, 8'hF0, 8'h10};
        tbl[1] = '{2'd1, 8'h05, 8'h07, 1'b0, 8'h05, 8'hFE};
        tbl[2] = '{2'd3, 8'h99, 8'h0F, 1'b1, 8'hFE, 8'hFF};
        tbl[3] = '{2'd2, 8'h11, 8'hF3, 1'b1, 8'hFF, 8'hF3};
        tbl[4] = '{2'd0, 8'h00, 8'h0D, 1'b1, 8'hF3, 8'h00};
        tbl[5] = '{2'd1, 8'h77, 8'h01, 1'b1, 8'h00, 8'hFF};
        tbl[6] = '{2'd2, 8'hAA, 8'h0F, 1'b0, 8'hAA, 8'h0A};
        tbl[7] = '{2'd3, 8'h50, 8'h05, 1'b0, 8'h50, 8'h55};
        tbl[8] = '{2'd0, 8'h3C, 8'h80, 1'b1, 8'h55, 8'hD5};
        tbl[9] = '{2'd1, 8'h00, 8'h80, 1'b0, 8'h00, 8'h80};

        n_checks = 0; n_fail = 0; cyc = 0; n_res = 0;
        rst = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        bus.res_ready = 1'b0;
        step(); step();
        check("reset count", 32'(bus.count), 32'd0);
        check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset res_valid", 32'(bus.res_valid), 32'd0);
        check("reset res_data", 32'(bus.res_data), 32'd0);
        check("reset alu", 32'({bus.alu_mode, bus.alu_left, bus.alu_right}), 32'd0);
        rst = 1'b0;
        step();

        // Vector table: one command at a time into an idle block, res_ready held high.
        bus.res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].mode, tbl[i].left, tbl[i].right, tbl[i].acc);
            step();
            bus.cmd_valid = 1'b0;
            check("vec count after push", 32'(bus.count), 32'd1);
            lat = 0;
            while (!bus.res_valid && lat < 8) begin
                step();
                lat++;
                if (lat == 1) begin
                    check("vec alu_left", 32'(bus.alu_left), 32'(tbl[i].exp_left));
                    check("vec alu_right/mode", 32'({bus.alu_mode, bus.alu_right}),
                          32'({tbl[i].mode, tbl[i].right}));
                end
            end
            check("vec latency", 32'(lat), 32'd2);
            check("vec res_data", 32'(bus.res_data), 32'(tbl[i].exp_res));
            step();
            check("vec res_valid pulse", 32'(bus.res_valid), 32'd0);
            check("vec count drained", 32'(bus.count), 32'd0);
        end

        // Chain: three back-to-back pushes, the last two reuse the accumulator.
        drive(1'b1, 2'd1, 8'h05, 8'h07, 1'b0); step(); c_acc = cyc;
        drive(1'b1, 2'd3, 8'h99, 8'h0F, 1'b1); step();
        drive(1'b1, 2'd2, 8'h11, 8'hF3, 1'b1); step();
        bus.cmd_valid = 1'b0;
        n_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.res_valid && n_seen < 3) begin
                t_res[n_seen] = cyc;
                d_res[n_seen] = bus.res_data;
                n_seen++;
            end
            step();
        end
        check("chain result count", 32'(n_seen), 32'd3);
        check("chain first latency", 32'(t_res[0] - c_acc), 32'd2);
        check("chain r0", 32'(d_res[0]), 32'hFE);
        check("chain r1", 32'(d_res[1]), 32'hFF);
        check("chain r2", 32'(d_res[2]), 32'hF3);
        check("chain spacing 0-1", 32'(t_res[1] - t_res[0]), 32'd2);
        check("chain spacing 1-2", 32'(t_res[2] - t_res[1]), 32'd2);

        // Backpressure: one result held for 10 cycles with a second command queued.
        bus.res_ready = 1'b0;
        drive(1'b1, 2'd0, 8'h12, 8'h34, 1'b0); step();
        drive(1'b1, 2'd1, 8'h50, 8'h10, 1'b0); step();
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 6 && !bus.res_valid; c++) step();
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp res_valid held", 32'(bus.res_valid), 32'd1);
            check("bp res_data held", 32'(bus.res_data), 32'h46);
            check("bp no issue", 32'({bus.alu_mode, bus.alu_left, bus.alu_right}), 32'd0);
            check("bp count", 32'(bus.count), 32'd1);
        end
        bus.res_ready = 1'b1;
        step();
        check("bp released valid low", 32'(bus.res_valid), 32'd0);
        check("bp next issue left", 32'(bus.alu_left), 32'h50);
        step();
        check("bp next valid", 32'(bus.res_valid), 32'd1);
        check("bp next data", 32'(bus.res_data), 32'h40);
        drain("bp");

        // Full FIFO: six back-to-back commands while the first result is held.
        bus.res_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            full_cmd(idx);
            acc_now = bus.cmd_valid && bus.cmd_ready;
            step();
            if (acc_now) idx++;
        end
        check("full accepted before stall", 32'(idx), 32'd5);
        check("full count", 32'(bus.count), 32'd4);
        check("full cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("full first held", 32'({bus.res_valid, bus.res_data}),
              32'({1'b1, ref_op(2'd0, 8'h03, 8'h21)}));
        bus.res_ready = 1'b1;
        n0 = n_res;
        for (int c = 0; c < 40; c++) begin
            if (idx >= 6 && exp_q.size() == 0 && !bus.res_valid && bus.count == '0) break;
            full_cmd(idx);
            acc_now = bus.cmd_valid && bus.cmd_ready;
            step();
            if (acc_now) idx++;
        end
        check("full all accepted", 32'(idx), 32'd6);
        check("full results delivered", 32'(n_res - n0), 32'd6);
        drain("full");

        // Simultaneous push and pop during ISSUE with count=2, repeated to wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            bus.res_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                rand_cmd();
                step();
            end
            bus.cmd_valid = 1'b0;
            check("pp count after push in issue", 32'(bus.count), 32'd2);
            check("pp holding", 32'(bus.res_valid), 32'd1);
            bus.res_ready = 1'b1;
            step();
            check("pp count entering issue", 32'(bus.count), 32'd2);
            check("pp issuing", 32'(bus.res_valid), 32'd0);
            rand_cmd();
            bus.res_ready = 1'b0;
            step();
            bus.cmd_valid = 1'b0;
            check("pp count after second push in issue", 32'(bus.count), 32'd2);
            check("pp holding again", 32'(bus.res_valid), 32'd1);
            drain("pp");
        end

        // Reset during ISSUE with three entries still queued.
        bus.res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_cmd();
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        step();
        check("rst pre count", 32'(bus.count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("rst async res_valid", 32'(bus.res_valid), 32'd0);
        check("rst async count", 32'(bus.count), 32'd0);
        check("rst async cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst async res_data", 32'(bus.res_data), 32'd0);
        check("rst async alu", 32'({bus.alu_mode, bus.alu_left, bus.alu_right}), 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("rst no stale result", 32'({bus.res_valid, bus.count}), 32'd0);
        end
        drive(1'b1, 2'd0, 8'hEE, 8'h33, 1'b1);
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        check("rst acc cleared valid", 32'(bus.res_valid), 32'd1);
        check("rst acc cleared data", 32'(bus.res_data), 32'h33);
        drain("rst");

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 500; c++) begin
            rand_cmd();
            bus.cmd_valid = ($urandom_range(0, 2) != 0);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
